mc_control_unit: RTL and testbench

- Next-generation multicycle MIPS control unit. Drives every datapath enable and mux select from a single Moore FSM.
- Generalised over the current control FSM in three ways:
  - configurable memory wait-state count, replacing the hard-wired wait states;
  - I-type, load/store, branch and jump support;
  - an exception sequence for illegal opcode and arithmetic overflow.
- Sits between the instruction register fields / ALU flags and the datapath muxes and registers.

---
 rtl/mc_ctrl_pkg.sv | 91 +++++++++
 rtl/mc_wait_counter.sv | 36 +++
 rtl/mc_control_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// funct codes and datapath mux/ALU select values.
package mc_ctrl_pkg;

  typedef enum logic [6:0] {
    ST_RESET    = 7'd0,
    ST_FETCH    = 7'd1,
    ST_MEM_WAIT = 7'd2,
    ST_DECODE   = 7'd3,
    ST_EXEC_R   = 7'd4,
    ST_R_WRITE  = 7'd7,
    ST_ADDI     = 7'd8,
    ST_I_WRITE  = 7'd9,
    ST_LW_ADDR  = 7'd10,
    ST_LW_MEM   = 7'd11,
    ST_LW_WRITE = 7'd12,
    ST_SW_ADDR  = 7'd13,
    ST_SW_MEM   = 7'd14,
    ST_BEQ      = 7'd15,
    ST_BNE      = 7'd16,
    ST_JUMP     = 7'd17,
    ST_JAL      = 7'd18,
    ST_JAL_WR   = 7'd19,
    ST_EXC_OPC  = 7'd20,
    ST_EXC_OVF  = 7'd21,
    ST_EXC_WAIT = 7'd22,
    ST_EXC_LOAD = 7'd23
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_LOADA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;

  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_IMM    = 3'b010;
  localparam logic [2:0] SRCB_IMMSH2 = 3'b011;

  localparam logic [2:0] PCSRC_ALU    = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_VEC    = 3'b011;

  localparam logic [2:0] DST_RT = 3'b000;
  localparam logic [2:0] DST_RD = 3'b001;
  localparam logic [2:0] DST_RA = 3'b011;
  localparam logic [2:0] DST_SP = 3'b100;

  localparam logic [2:0] MREG_ALUOUT = 3'b000;
  localparam logic [2:0] MREG_MDR    = 3'b001;
  localparam logic [2:0] MREG_SPINIT = 3'b111;

  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_ALUOUT = 2'b01;
  localparam logic [1:0] IORD_VEC    = 2'b10;

  function automatic logic is_valid_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) ||
           (funct == FN_AND) || (funct == FN_SLT);
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_SLT:  return ALU_SLT;
      default: return ALU_LOADA;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory wait-state counter: loads MEM_WAIT-1 on entry to a wait state and
// reports done once it has counted down to zero.
module mc_wait_counter #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam logic [3:0] LOAD_VAL = 4'(MEM_WAIT - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: one Moore FSM driving every datapath enable
// and mux select, with configurable memory wait states and exception entry.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT    = 2,
  parameter int unsigned RST_CYCLES  = 1,
  parameter logic [2:0]  EXC_OPC_VEC = 3'b000,
  parameter logic [2:0]  EXC_OVF_VEC = 3'b001
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [5:0] OPCode,
  input  logic [5:0] Funct,
  input  logic       Overflow,
  input  logic       EQ,
  output logic [6:0] Estado,
  output logic       flagPcWrite,
  output logic [1:0] flagIorD,
  output logic       flagMemCtrl,
  output logic       flagIrWrite,
  output logic       flagMDR,
  output logic       flagRegA,
  output logic       flagRegB,
  output logic       flagRegWrite,
  output logic [2:0] flagRegDist,
  output logic [2:0] flagMemReg,
  output logic [1:0] flagALUSrcA,
  output logic [2:0] flagALUSrcB,
  output logic [2:0] flagALUCtrl,
  output logic       flagALUOut,
  output logic [2:0] flagPCSrc,
  output logic       flagEPC,
  output logic [2:0] flagExcpCtrl,
  output logic       flagRegReset
);

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] rst_cnt_q, rst_cnt_d;
  logic       wait_load;
  logic       wait_done;

  // States whose successor is a memory wait preload the counter on exit
  assign wait_load = (state_q == ST_FETCH) || (state_q == ST_LW_ADDR) ||
                     (state_q == ST_EXC_OPC) || (state_q == ST_EXC_OVF);

  mc_wait_counter #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk  (Clock),
    .rst_n(Reset_n),
    .load (wait_load),
    .done (wait_done)
  );

  always_comb begin
    rst_cnt_d = (state_q == ST_RESET) ? rst_cnt_q + 4'd1 : 4'd0;
    state_d   = state_q;
    case (state_q)
      ST_RESET:    if (rst_cnt_q >= RST_LAST) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (wait_done) state_d = ST_DECODE;
      ST_DECODE: begin
        case (OPCode)
          OP_RTYPE: state_d = is_valid_funct(Funct) ? ST_EXEC_R : ST_EXC_OPC;
          OP_ADDI:  state_d = ST_ADDI;
          OP_LW:    state_d = ST_LW_ADDR;
          OP_SW:    state_d = ST_SW_ADDR;
          OP_BEQ:   state_d = ST_BEQ;
          OP_BNE:   state_d = ST_BNE;
          OP_J:     state_d = ST_JUMP;
          OP_JAL:   state_d = ST_JAL;
          default:  state_d = ST_EXC_OPC;
        endcase
      end
      ST_EXEC_R:
        state_d = (Overflow && ((Funct == FN_ADD) || (Funct == FN_SUB))) ?
                  ST_EXC_OVF : ST_R_WRITE;
      ST_ADDI:     state_d = Overflow ? ST_EXC_OVF : ST_I_WRITE;
      ST_LW_ADDR:  state_d = ST_LW_MEM;
      ST_LW_MEM:   if (wait_done) state_d = ST_LW_WRITE;
      ST_SW_ADDR:  state_d = ST_SW_MEM;
      ST_JAL:      state_d = ST_JAL_WR;
      ST_EXC_OPC:  state_d = ST_EXC_WAIT;
      ST_EXC_OVF:  state_d = ST_EXC_WAIT;
      ST_EXC_WAIT: if (wait_done) state_d = ST_EXC_LOAD;
      ST_R_WRITE, ST_I_WRITE, ST_LW_WRITE, ST_SW_MEM, ST_BEQ, ST_BNE,
      ST_JUMP, ST_JAL_WR, ST_EXC_LOAD:
        state_d = ST_FETCH;
      default:     state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_RESET;
      rst_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign Estado = state_q;

  // Moore decode; the only input dependences are branch resolution on EQ
  // and the ALU op chosen by Funct while executing an R-type
  always_comb begin
    flagPcWrite  = 1'b0;
    flagIorD     = IORD_PC;
    flagMemCtrl  = 1'b0;
    flagIrWrite  = 1'b0;
    flagMDR      = 1'b0;
    flagRegA     = 1'b0;
    flagRegB     = 1'b0;
    flagRegWrite = 1'b0;
    flagRegDist  = DST_RT;
    flagMemReg   = MREG_ALUOUT;
    flagALUSrcA  = SRCA_PC;
    flagALUSrcB  = SRCB_B;
    flagALUCtrl  = ALU_LOADA;
    flagALUOut   = 1'b0;
    flagPCSrc    = PCSRC_ALU;
    flagEPC      = 1'b0;
    flagExcpCtrl = 3'b000;
    flagRegReset = 1'b0;
    case (state_q)
      ST_RESET: begin
        flagRegReset = 1'b1;
        flagRegWrite = 1'b1;
        flagRegDist  = DST_SP;
        flagMemReg   = MREG_SPINIT;
      end
      ST_FETCH: begin
        flagALUSrcB = SRCB_FOUR;
        flagALUCtrl = ALU_ADD;
        flagPcWrite = 1'b1;
      end
      ST_MEM_WAIT: flagIrWrite = wait_done;
      ST_DECODE: begin
        flagRegA    = 1'b1;
        flagRegB    = 1'b1;
        flagALUSrcB = SRCB_IMMSH2;
        flagALUCtrl = ALU_ADD;
        flagALUOut  = 1'b1;
      end
      ST_EXEC_R: begin
        flagALUSrcA = SRCA_A;
        flagALUCtrl = alu_for_funct(Funct);
        flagALUOut  = 1'b1;
      end
      ST_R_WRITE: begin
        flagRegWrite = 1'b1;
        flagRegDist  = DST_RD;
      end
      ST_ADDI, ST_LW_ADDR, ST_SW_ADDR: begin
        flagALUSrcA = SRCA_A;
        flagALUSrcB = SRCB_IMM;
        flagALUCtrl = ALU_ADD;
        flagALUOut  = 1'b1;
      end
      ST_I_WRITE: flagRegWrite = 1'b1;
      ST_LW_MEM: begin
        flagIorD = IORD_ALUOUT;
        flagMDR  = wait_done;
      end
      ST_LW_WRITE: begin
        flagRegWrite = 1'b1;
        flagMemReg   = MREG_MDR;
      end
      ST_SW_MEM: begin
        flagIorD    = IORD_ALUOUT;
        flagMemCtrl = 1'b1;
      end
      ST_BEQ, ST_BNE: begin
        flagALUSrcA = SRCA_A;
        flagALUCtrl = ALU_SUB;
        flagPCSrc   = PCSRC_ALUOUT;
        flagPcWrite = (state_q == ST_BEQ) ? EQ : !EQ;
      end
      ST_JUMP: begin
        flagPCSrc   = PCSRC_JUMP;
        flagPcWrite = 1'b1;
      end
      ST_JAL: flagALUOut = 1'b1;
      ST_JAL_WR: begin
        flagRegWrite = 1'b1;
        flagRegDist  = DST_RA;
        flagPCSrc    = PCSRC_JUMP;
        flagPcWrite  = 1'b1;
      end
      ST_EXC_OPC, ST_EXC_OVF: begin
        flagALUSrcB  = SRCB_FOUR;
        flagALUCtrl  = ALU_SUB;
        flagEPC      = 1'b1;
        flagExcpCtrl = (state_q == ST_EXC_OPC) ? EXC_OPC_VEC : EXC_OVF_VEC;
        flagIorD     = IORD_VEC;
      end
      ST_EXC_WAIT: flagMDR = wait_done;
      ST_EXC_LOAD: begin
        flagPCSrc   = PCSRC_VEC;
        flagPcWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-cycle expected state and control
// vectors are queued with each instruction and compared on the falling edge.
module tb_mc_control_unit;

  typedef struct packed {
    logic       pcWrite;
    logic [1:0] iorD;
    logic       memCtrl;
    logic       irWrite;
    logic       mdr;
    logic       regA;
    logic       regB;
    logic       regWrite;
    logic [2:0] regDist;
    logic [2:0] memReg;
    logic [1:0] srcA;
    logic [2:0] srcB;
    logic [2:0] aluCtrl;
    logic       aluOut;
    logic [2:0] pcSrc;
    logic       epc;
    logic [2:0] excp;
    logic       regReset;
  } ctrl_t;

  typedef struct packed {
    logic [6:0] st;
    ctrl_t      outs;
  } entry_t;

  logic       Clock, Reset_n;
  logic [5:0] OPCode, Funct, opc4, fn4;
  logic       Overflow, EQ, ovf4, eq4;

  logic [6:0] Estado, estado4;
  logic       flagPcWrite, flagMemCtrl, flagIrWrite, flagMDR, flagRegA, flagRegB;
  logic       flagRegWrite, flagALUOut, flagEPC, flagRegReset;
  logic [1:0] flagIorD, flagALUSrcA;
  logic [2:0] flagRegDist, flagMemReg, flagALUSrcB, flagALUCtrl, flagPCSrc, flagExcpCtrl;
  logic       pcWrite4, memCtrl4, irWrite4, mdr4, regA4, regB4, regWrite4, aluOut4, epc4, regReset4;
  logic [1:0] iorD4, srcA4;
  logic [2:0] regDist4, memReg4, srcB4, aluCtrl4, pcSrc4, excp4;

  ctrl_t  obsMain, obs4;
  entry_t sb[$];
  entry_t sb4[$];
  entry_t eMain, eFour;
  int     seqBuf[$];
  int     checks = 0;
  int     failures = 0;

  assign obsMain = {flagPcWrite, flagIorD, flagMemCtrl, flagIrWrite, flagMDR, flagRegA,
                    flagRegB, flagRegWrite, flagRegDist, flagMemReg, flagALUSrcA,
                    flagALUSrcB, flagALUCtrl, flagALUOut, flagPCSrc, flagEPC,
                    flagExcpCtrl, flagRegReset};
  assign obs4 = {pcWrite4, iorD4, memCtrl4, irWrite4, mdr4, regA4, regB4, regWrite4,
                 regDist4, memReg4, srcA4, srcB4, aluCtrl4, aluOut4, pcSrc4, epc4,
                 excp4, regReset4};

  mc_control_unit #(.MEM_WAIT(2), .RST_CYCLES(1), .EXC_OPC_VEC(3'b000), .EXC_OVF_VEC(3'b001)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .OPCode(OPCode), .Funct(Funct),
    .Overflow(Overflow), .EQ(EQ), .Estado(Estado), .flagPcWrite(flagPcWrite),
    .flagIorD(flagIorD), .flagMemCtrl(flagMemCtrl), .flagIrWrite(flagIrWrite),
    .flagMDR(flagMDR), .flagRegA(flagRegA), .flagRegB(flagRegB),
    .flagRegWrite(flagRegWrite), .flagRegDist(flagRegDist), .flagMemReg(flagMemReg),
    .flagALUSrcA(flagALUSrcA), .flagALUSrcB(flagALUSrcB), .flagALUCtrl(flagALUCtrl),
    .flagALUOut(flagALUOut), .flagPCSrc(flagPCSrc), .flagEPC(flagEPC),
    .flagExcpCtrl(flagExcpCtrl), .flagRegReset(flagRegReset)
  );

  mc_control_unit #(.MEM_WAIT(4), .RST_CYCLES(1), .EXC_OPC_VEC(3'b000), .EXC_OVF_VEC(3'b001)) dut4 (
    .Clock(Clock), .Reset_n(Reset_n), .OPCode(opc4), .Funct(fn4),
    .Overflow(ovf4), .EQ(eq4), .Estado(estado4), .flagPcWrite(pcWrite4),
    .flagIorD(iorD4), .flagMemCtrl(memCtrl4), .flagIrWrite(irWrite4),
    .flagMDR(mdr4), .flagRegA(regA4), .flagRegB(regB4),
    .flagRegWrite(regWrite4), .flagRegDist(regDist4), .flagMemReg(memReg4),
    .flagALUSrcA(srcA4), .flagALUSrcB(srcB4), .flagALUCtrl(aluCtrl4),
    .flagALUOut(aluOut4), .flagPCSrc(pcSrc4), .flagEPC(epc4),
    .flagExcpCtrl(excp4), .flagRegReset(regReset4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected control vector for one cycle in state st; last marks the final
  // cycle of a memory wait
  function automatic ctrl_t expOuts(input int st, input logic last, input logic eqv,
                                    input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.regReset = 1; c.regWrite = 1; c.regDist = 3'b100; c.memReg = 3'b111; end
      1:  begin c.srcB = 3'b001; c.aluCtrl = 3'b001; c.pcWrite = 1; end
      2:  c.irWrite = last;
      3:  begin c.regA = 1; c.regB = 1; c.srcB = 3'b011; c.aluCtrl = 3'b001; c.aluOut = 1; end
      4:  begin
        c.srcA = 2'b01; c.aluOut = 1;
        case (fn)
          6'h20: c.aluCtrl = 3'b001;
          6'h22: c.aluCtrl = 3'b010;
          6'h24: c.aluCtrl = 3'b011;
          6'h2A: c.aluCtrl = 3'b111;
          default: c.aluCtrl = 3'b000;
        endcase
      end
      7:  begin c.regWrite = 1; c.regDist = 3'b001; end
      8, 10, 13: begin c.srcA = 2'b01; c.srcB = 3'b010; c.aluCtrl = 3'b001; c.aluOut = 1; end
      9:  c.regWrite = 1;
      11: begin c.iorD = 2'b01; c.mdr = last; end
      12: begin c.regWrite = 1; c.memReg = 3'b001; end
      14: begin c.iorD = 2'b01; c.memCtrl = 1; end
      15: begin c.srcA = 2'b01; c.aluCtrl = 3'b010; c.pcSrc = 3'b001; c.pcWrite = eqv; end
      16: begin c.srcA = 2'b01; c.aluCtrl = 3'b010; c.pcSrc = 3'b001; c.pcWrite = !eqv; end
      17: begin c.pcSrc = 3'b010; c.pcWrite = 1; end
      18: c.aluOut = 1;
      19: begin c.regWrite = 1; c.regDist = 3'b011; c.pcSrc = 3'b010; c.pcWrite = 1; end
      20, 21: begin
        c.srcB = 3'b001; c.aluCtrl = 3'b010; c.epc = 1; c.iorD = 2'b10;
        c.excp = (st == 20) ? 3'b000 : 3'b001;
      end
      22: c.mdr = last;
      23: begin c.pcSrc = 3'b011; c.pcWrite = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic pushSeq(input bit toFour, input logic eqv, input logic [5:0] fn);
    entry_t e;
    logic   last;
    for (int i = 0; i < seqBuf.size(); i++) begin
      last = 1'b1;
      if (i + 1 < seqBuf.size()) last = (seqBuf[i+1] != seqBuf[i]);
      e.st   = 7'(seqBuf[i]);
      e.outs = expOuts(seqBuf[i], last, eqv, fn);
      if (toFour) sb4.push_back(e);
      else        sb.push_back(e);
    end
  endtask

  task automatic waitDrain();
    int budget;
    budget = 200;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge Clock);
      #1;
      budget--;
    end
    if (budget == 0) checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
  endtask

  // Starts one instruction at its FETCH cycle; seqBuf holds its state trace
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic ovf, input logic eqv);
    waitDrain();
    OPCode   = op;
    Funct    = fn;
    Overflow = ovf;
    EQ       = eqv;
    pushSeq(1'b0, eqv, fn);
  endtask

  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      eMain = sb.pop_front();
      checkOutput($sformatf("main.st%0d.estado", eMain.st), 32'(Estado), 32'(eMain.st));
      checkOutput($sformatf("main.st%0d.ctrl", eMain.st), obsMain, eMain.outs);
    end
  end

  always @(negedge Clock) begin
    if (sb4.size() > 0) begin
      eFour = sb4.pop_front();
      checkOutput($sformatf("wait4.st%0d.estado", eFour.st), 32'(estado4), 32'(eFour.st));
      checkOutput($sformatf("wait4.st%0d.ctrl", eFour.st), obs4, eFour.outs);
    end
  end

  initial begin
    Reset_n = 1'b0; OPCode = 6'h00; Funct = 6'h00; Overflow = 1'b0; EQ = 1'b0;
    opc4 = 6'h23; fn4 = 6'h00; ovf4 = 1'b0; eq4 = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checkOutput("resetEstado", 32'(Estado), 32'd0);
    checkOutput("resetRegReset", 32'(flagRegReset), 32'd1);
    Reset_n = 1'b1;
    seqBuf = '{0};
    pushSeq(1'b0, 1'b0, 6'h00);
    seqBuf = '{0, 1,2,2,2,2,3,10,11,11,11,11,12, 1,2,2,2,2,3,10,11,11,11,11,12};
    pushSeq(1'b1, 1'b0, 6'h00);

    seqBuf = '{1,2,2,3,4,7};          applyStimulus(6'h00, 6'h22, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,4,7};          applyStimulus(6'h00, 6'h24, 1'b1, 1'b0);
    seqBuf = '{1,2,2,3,4,7};          applyStimulus(6'h00, 6'h2A, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,8,21,22,22,23}; applyStimulus(6'h08, 6'h00, 1'b1, 1'b0);
    seqBuf = '{1,2,2,3,8,9};          applyStimulus(6'h08, 6'h00, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,15};           applyStimulus(6'h04, 6'h00, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,16};           applyStimulus(6'h05, 6'h00, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,15};           applyStimulus(6'h04, 6'h00, 1'b0, 1'b1);
    seqBuf = '{1,2,2,3,10,11,11,12};  applyStimulus(6'h23, 6'h00, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,17};           applyStimulus(6'h02, 6'h00, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,18,19};        applyStimulus(6'h03, 6'h00, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,20,22,22,23};  applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,20,22,22,23};  applyStimulus(6'h00, 6'h21, 1'b0, 1'b0);
    seqBuf = '{1,2,2,3,4,21,22,22,23}; applyStimulus(6'h00, 6'h20, 1'b1, 1'b0);
    checkOutput("wait4Drained", 32'(sb4.size()), 32'd0);

    // Store is stopped by an asynchronous reset in the middle of SW_MEM
    seqBuf = '{1,2,2,3,13};           applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
    waitDrain();
    checkOutput("swMemEstado", 32'(Estado), 32'd14);
    checkOutput("swMemWrite", 32'(flagMemCtrl), 32'd1);
    #1;
    Reset_n = 1'b0;
    #1;
    checkOutput("asyncEstado", 32'(Estado), 32'd0);
    checkOutput("asyncMemWrite", 32'(flagMemCtrl), 32'd0);
    checkOutput("asyncRegReset", 32'(flagRegReset), 32'd1);
    repeat (2) @(posedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
